// File: rtl/univ_reg_seq_ctrl_pkg.sv
// Shared types for the universal shift register and its command sequencer.
// Mode encoding matches the register's mode pins so commands pass straight through.
package univ_reg_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      MODE_SISO = 2'b00,
      MODE_SIPO = 2'b01,
      MODE_PISO = 2'b10,
      MODE_PIPO = 2'b11
   } reg_mode_t;

   typedef logic [2:0] seq_state_t;

   localparam seq_state_t ST_IDLE    = 3'd0;
   localparam seq_state_t ST_LOAD    = 3'd1;
   localparam seq_state_t ST_SHIFT   = 3'd2;
   localparam seq_state_t ST_CAPTURE = 3'd3;
   localparam seq_state_t ST_DONE    = 3'd4;

endpackage

// File: rtl/univ_reg_seq_ctrl_bit_counter.sv
// Serial bit counter: clears on clr, steps on en, flags the terminal count TC.
// Wraps to zero when stepped at TC so a fresh transfer never sees stale state.
module bit_counter #(
   parameter int W  = 4,
   parameter int TC = 7
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tc ? '0 : cnt + W'(1);
      end
   end

   assign tc = (cnt == W'(TC));

endmodule

// File: rtl/univ_reg_seq_ctrl.sv
// Command sequencer for the universal shift register: one transfer at a time, response held until rsp_ready.
// Latency: PIPO 3, SISO/SIPO WIDTH+2, PISO WIDTH+3 cycles plus one per stalled shift; cmd_ready low while busy.
module univ_reg_seq_ctrl
   import univ_reg_pkg::*;
#(
   parameter int WIDTH = DATA_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             ser_in,
   input  logic             ser_stall,
   input  logic             abort,
   output logic             ser_strobe,
   output logic             ser_out,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             busy,
   output logic             reg_enable,
   output logic [1:0]       reg_mode,
   output logic             reg_load,
   output logic             reg_serial_in,
   output logic [WIDTH-1:0] reg_parallel_in,
   input  logic             reg_serial_out,
   input  logic [WIDTH-1:0] reg_parallel_out
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   seq_state_t       state;
   seq_state_t       state_nxt;
   reg_mode_t        op;
   logic [WIDTH-1:0] data;
   logic             accept;
   logic             shift_go;
   logic             cnt_tc;

   assign cmd_ready = (state == ST_IDLE) && !abort;
   assign accept    = cmd_valid && cmd_ready;
   assign shift_go  = (state == ST_SHIFT) && !ser_stall;

   bit_counter #(
      .W  (CNT_W),
      .TC (WIDTH - 1)
   ) u_bit_counter (
      .clk (clk),
      .rst (rst),
      .clr (accept),
      .en  (shift_go),
      .tc  (cnt_tc)
   );

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:    if (accept) state_nxt = cmd_op[1] ? ST_LOAD : ST_SHIFT;
         ST_LOAD:    state_nxt = (op == MODE_PIPO) ? ST_CAPTURE : ST_SHIFT;
         ST_SHIFT:   if (shift_go && cnt_tc) state_nxt = ST_CAPTURE;
         ST_CAPTURE: state_nxt = ST_DONE;
         ST_DONE:    if (rsp_ready) state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
      // Abort outranks rsp_ready and stall; a pending response is simply dropped.
      if (abort && (state != ST_IDLE)) state_nxt = ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         op       <= MODE_SISO;
         data     <= '0;
         rsp_data <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op   <= reg_mode_t'(cmd_op);
            data <= cmd_data;
         end
         if ((state == ST_CAPTURE) && !abort) rsp_data <= reg_parallel_out;
      end
   end

   assign busy            = (state != ST_IDLE);
   assign rsp_valid       = (state == ST_DONE);
   assign reg_load        = (state == ST_LOAD);
   assign reg_enable      = reg_load || shift_go;
   assign ser_strobe      = shift_go;
   assign reg_mode        = op;
   assign reg_parallel_in = data;
   assign reg_serial_in   = (state == ST_SHIFT) && ser_in;
   assign ser_out         = reg_serial_out;

endmodule

// File: tb/tb_univ_reg_seq_ctrl.sv
// Bench for univ_reg_seq_ctrl with a behavioural shift register attached to its reg_* pins.
// Expected timing and results come from a transfer-level phase walk, not from the DUT.
module tb_univ_reg_seq_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [1:0]   cmd_op = 2'b00;
   logic [W-1:0] cmd_data = '0;
   logic         ser_in = 1'b0;
   logic         ser_stall = 1'b0;
   logic         abort = 1'b0;
   logic         ser_strobe;
   logic         ser_out;
   logic         rsp_valid;
   logic         rsp_ready = 1'b0;
   logic [W-1:0] rsp_data;
   logic         busy;
   logic         reg_enable;
   logic [1:0]   reg_mode;
   logic         reg_load;
   logic         reg_serial_in;
   logic [W-1:0] reg_parallel_in;
   logic         reg_serial_out;
   logic [W-1:0] reg_parallel_out;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   univ_reg_seq_ctrl #(.WIDTH(W)) dut (
      .clk              (clk),
      .rst              (rst),
      .cmd_valid        (cmd_valid),
      .cmd_ready        (cmd_ready),
      .cmd_op           (cmd_op),
      .cmd_data         (cmd_data),
      .ser_in           (ser_in),
      .ser_stall        (ser_stall),
      .abort            (abort),
      .ser_strobe       (ser_strobe),
      .ser_out          (ser_out),
      .rsp_valid        (rsp_valid),
      .rsp_ready        (rsp_ready),
      .rsp_data         (rsp_data),
      .busy             (busy),
      .reg_enable       (reg_enable),
      .reg_mode         (reg_mode),
      .reg_load         (reg_load),
      .reg_serial_in    (reg_serial_in),
      .reg_parallel_in  (reg_parallel_in),
      .reg_serial_out   (reg_serial_out),
      .reg_parallel_out (reg_parallel_out)
   );

   // Register model: parallel load in modes 1x, otherwise shift left, MSB is the serial output.
   logic [W-1:0] shreg;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) shreg <= '0;
      else if (reg_enable) begin
         if (reg_load && reg_mode[1]) shreg <= reg_parallel_in;
         else if (!reg_load)          shreg <= {shreg[W-2:0], reg_serial_in};
      end
   end
   assign reg_parallel_out = shreg;
   assign reg_serial_out   = shreg[W-1];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One complete transfer. bits[i] is the i-th serial bit presented; abort_at >= 0 aborts in SHIFT.
   task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] dat, input logic [W-1:0] bits,
                          input int stall_pct, input int stall_after, input int stall_len,
                          input int hold, input int abort_at);
      int phase;      // 0 load, 1 shift, 2 capture, 3 done
      int shifts = 0;
      int cyc = 0;
      int nstall = 0;
      int forced = 0;
      int exp_lat;
      logic st;
      logic [W-1:0] exp_rsp = '0;

      for (int i = 0; i < W; i++) exp_rsp = {exp_rsp[W-2:0], bits[i]};
      if (op == 2'b11) exp_rsp = dat;
      exp_lat = (op == 2'b11) ? 3 : (op == 2'b10) ? W + 3 : W + 2;

      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_data = dat; abort = 1'b0; rsp_ready = 1'b0;
      #1;
      check("accept_ready", cmd_ready, 1);
      check("accept_idle", busy, 0);

      phase = op[1] ? 0 : 1;
      while (phase != 3) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         cmd_op = 2'($urandom_range(3));
         cmd_data = W'($urandom);
         cyc++;
         if (phase == 1 && shifts == abort_at) begin
            abort = 1'b1; ser_stall = 1'b1;
            #1;
            check("abort_cycle_busy", busy, 1);
            @(negedge clk);
            abort = 1'b0; ser_stall = 1'b0;
            #1;
            check("abort_busy", busy, 0);
            check("abort_rsp_valid", rsp_valid, 0);
            check("abort_enable", reg_enable, 0);
            check("abort_ready", cmd_ready, 1);
            return;
         end
         st = 1'b0;
         if (phase == 1 && shifts == stall_after && forced < stall_len) begin
            st = 1'b1; forced++;
         end else if (stall_pct > 0 && int'($urandom_range(99)) < stall_pct) begin
            st = 1'b1;
         end
         ser_stall = st;
         ser_in = (shifts < W) ? bits[shifts] : 1'b0;
         #1;
         check("busy_in_xfer", busy, 1);
         check("no_accept_busy", cmd_ready, 0);
         check("mode_follows_op", reg_mode, op);
         case (phase)
            0: begin
               check("load_pulse", reg_load, 1);
               check("load_enable", reg_enable, 1);
               check("load_data", reg_parallel_in, dat);
               check("load_no_strobe", ser_strobe, 0);
               phase = (op == 2'b11) ? 2 : 1;
            end
            1: begin
               check("shift_load", reg_load, 0);
               check("shift_strobe", ser_strobe, !st);
               check("shift_enable", reg_enable, !st);
               check("shift_ser_in", reg_serial_in, ser_in);
               if (op == 2'b10) check("piso_ser_out", ser_out, dat[W-1-shifts]);
               if (st) nstall++;
               else    shifts++;
               if (shifts == W) phase = 2;
            end
            default: begin
               check("capture_enable", reg_enable, 0);
               check("capture_load", reg_load, 0);
               check("capture_rsp_valid", rsp_valid, 0);
               phase = 3;
            end
         endcase
      end

      for (int h = 0; h <= hold; h++) begin
         @(negedge clk);
         ser_stall = 1'b0;
         rsp_ready = (h == hold);
         #1;
         if (h == 0) check("latency", cyc + 1, exp_lat + nstall);
         check("done_rsp_valid", rsp_valid, 1);
         check("done_rsp_data", rsp_data, exp_rsp);
         check("done_ready", cmd_ready, 0);
         check("done_enable", reg_enable, 0);
      end
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      check("back_idle", busy, 0);
      check("idle_rsp_valid", rsp_valid, 0);
   endtask

   initial begin
      // Reset held for 2 cycles
      repeat (2) @(negedge clk);
      #1;
      check("rst_enable_async", reg_enable, 0);
      check("rst_busy_async", busy, 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_enable", reg_enable, 0);
      check("rst_load", reg_load, 0);
      check("rst_mode", reg_mode, 0);
      check("rst_ser_in", reg_serial_in, 0);
      check("rst_par_in", reg_parallel_in, 0);
      check("rst_strobe", ser_strobe, 0);
      check("rst_ready", cmd_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);

      // Directed transfers
      run_cmd(2'b11, 8'hEF, 8'h00, 0, -1, 0, 0, -1);
      run_cmd(2'b10, 8'hDB, 8'hA6, 0, -1, 0, 0, -1);
      run_cmd(2'b01, 8'h00, 8'h11, 0, 3, 3, 0, -1);
      run_cmd(2'b01, 8'h00, 8'hFF, 0, -1, 0, 0, 4);
      run_cmd(2'b11, 8'h5A, 8'h00, 0, -1, 0, 0, -1);
      run_cmd(2'b00, 8'h00, 8'h3C, 0, -1, 0, 5, -1);

      // Abort in IDLE blocks acceptance
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = 8'h77; abort = 1'b1;
      #1;
      check("idle_abort_ready", cmd_ready, 0);
      @(negedge clk);
      cmd_valid = 1'b0; abort = 1'b0;
      #1;
      check("idle_abort_no_accept", busy, 0);

      // Randomized transfers with random stalls and response holds
      for (int n = 0; n < 24; n++)
         run_cmd(2'($urandom_range(3)), W'($urandom), W'($urandom), 30, -1, 0,
                 int'($urandom_range(3)), -1);

      // Asynchronous reset in the middle of a SIPO transfer
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 8'h00; ser_in = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("mid_sipo_enable", reg_enable, 1);
      #2;
      rst = 1'b0;
      #1;
      check("arst_enable", reg_enable, 0);
      check("arst_busy", busy, 0);
      check("arst_strobe", ser_strobe, 0);
      check("arst_rsp_data", rsp_data, 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("arst_ready", cmd_ready, 1);
      run_cmd(2'b11, 8'hC3, 8'h00, 0, -1, 0, 0, -1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/univ_reg_seq_ctrl.md
Name: univ_reg_seq_ctrl

Overview:
Command-driven sequencer for the Hamming-protected 8-bit universal shift register (`top`: SISO/SIPO/PISO/PIPO).
- Accepts one transfer command at a time over a valid/ready interface.
- Drives the register's enable, mode, load and data pins, and counts serial bits.
- Supports stall and abort.
- Returns the register's final parallel word over a valid/ready response interface.
- Sits between the system bus logic and the register instance.

Parameters:
- WIDTH, 8, register data width and serial bits per SISO/SIPO/PISO transfer.
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  00 SISO, 01 SIPO, 10 PISO, 11 PIPO (same encoding as register mode).
- cmd_data  in  WIDTH  parallel word for PISO/PIPO; ignored otherwise.
- ser_in  in  1  serial source bit.
- ser_stall  in  1  freeze shifting this cycle.
- abort  in  1  synchronous cancel of the current command.
- ser_strobe  out  1  one bit is shifted at the next rising edge.
- ser_out  out  1  equals reg_serial_out (pass-through).
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_data  out  WIDTH  captured reg_parallel_out.
- busy  out  1  state != IDLE.
- reg_enable  out  1  to register enable.
- reg_mode  out  2  to register mode.
- reg_load  out  1  to register load.
- reg_serial_in  out  1  to register serial_in.
- reg_parallel_in  out  WIDTH  to register parallel_in.
- reg_serial_out  in  1  from register.
- reg_parallel_out  in  WIDTH  from register.

Behaviour:
- Register contract:
  - enable, mode, load and serial_in are sampled at the rising edge.
  - load=1 with enable=1 in modes 10/11 loads parallel_in.
  - enable=1 with load=0 shifts one bit.
- FSM states: IDLE, LOAD, SHIFT, CAPTURE, DONE. State is registered; outputs are decoded from state and latched fields.
- IDLE:
  - cmd_ready = !abort.
  - On cmd_valid&&cmd_ready, latch op and data, clear cnt.
  - Next state is LOAD if op[1], else SHIFT.
- LOAD (one cycle, ser_stall ignored):
  - reg_enable=1, reg_load=1, reg_mode=op, reg_parallel_in=data.
  - Next state is SHIFT for PISO, CAPTURE for PIPO.
- SHIFT:
  - reg_mode=op, reg_load=0, reg_enable=!ser_stall, ser_strobe=!ser_stall.
  - reg_serial_in=ser_in; it is 0 in every other state.
  - cnt increments on each unstalled cycle.
  - Exit to CAPTURE after the cycle where cnt reaches WIDTH-1 unstalled (exactly WIDTH shifts).
- CAPTURE: reg_enable=0; rsp_data <= reg_parallel_out; next state DONE.
- DONE:
  - rsp_valid=1; rsp_data is stable.
  - On rsp_ready, go to IDLE.
- Latency without stalls, with accept in cycle A:
  - PIPO: rsp_valid in A+3.
  - SIPO/SISO: rsp_valid in A+WIDTH+2.
  - PISO: rsp_valid in A+WIDTH+3.
  - Each stalled SHIFT cycle adds 1.
- Abort:
  - In LOAD/SHIFT/CAPTURE/DONE, go to IDLE at the next edge with no response; any pending rsp_valid is dropped.
  - Abort has priority over rsp_ready and over stall.
  - In IDLE, abort blocks acceptance that cycle.
- reg_mode holds the latched op in all states; it is 00 after reset.
- Reset (asynchronous, rst=0):
  - State goes to IDLE; cnt, op, data and rsp_data are cleared.
  - reg_enable, reg_load, ser_strobe, rsp_valid and busy are 0 immediately, including mid-transfer.
  - cmd_ready=1 once in IDLE.
- No command queueing: cmd_ready is 0 whenever busy.

Decomposition:
- Package univ_reg_pkg holds:
  - typedef reg_mode_t (SISO, SIPO, PISO, PIPO; 2-bit enum shared with the register).
  - typedef seq_state_t.
  - constant DATA_W=8.
- Sub-module bit_counter (CNT_W up-counter with clear, enable and terminal-count flag) is natural; the FSM stays in the top.

Test Plan:
All scenarios instantiate the register `top` connected to the controller, with WIDTH=8.
1. Reset: hold rst=0 for 2 cycles, then release -> all reg_* outputs 0, cmd_ready=1, busy=0, rsp_valid=0.
2. PIPO with cmd_data=8'hEF -> reg_load=1 for exactly one cycle in A+1 with reg_parallel_in=8'hEF; rsp_valid in A+3 with rsp_data=8'hEF.
3. PISO with 8'hDB -> one load cycle, then 8 ser_strobe pulses; ser_out matches the register model's shift order; rsp_valid in A+11.
4. SIPO, ser_in=1,0,0,0,1,0,0,0, ser_stall high for 3 cycles after bit 2 -> reg_enable=0 during the stall and cnt frozen; rsp_valid in A+13; rsp_data equals the register model value.
5. Abort during SHIFT at cnt=4 -> IDLE next cycle, no rsp_valid, reg_enable=0; a following PIPO 8'h5A completes normally.
6. Hold rsp_ready=0 for 5 cycles in DONE -> rsp_data stable, cmd_ready=0. Then pull rst low mid-SIPO -> reg_enable drops asynchronously and busy=0.
